// File: rtl/mem_access_guard.sv
// Memory-access guard: a region table classifies each load/store; the first fault is held in a capture register.
// Latency is 1 cycle from request to res_*, and capture/err_cnt follow one cycle after res_*. There is no backpressure: one check per cycle.
// The optional saturating fault counter is enabled by defining MAG_ERRCNT_EN; otherwise err_cnt is tied to 0.
module mem_access_guard #(
  parameter int ADDR_W      = 32,
  parameter int NUM_REGIONS = 8,
  parameter int IDX_W       = 3,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              chk_valid,
  input  logic [ADDR_W-1:0] chk_addr,
  input  logic [1:0]        chk_size,
  input  logic              chk_write,
  output logic              res_valid,
  output logic              res_error,
  output logic [2:0]        res_cause,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [1:0]        cfg_sel,
  input  logic [ADDR_W-1:0] cfg_wdata,
  output logic              cap_valid,
  output logic [ADDR_W-1:0] cap_addr,
  output logic [2:0]        cap_cause,
  output logic              cap_write,
  input  logic              cap_clr,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam logic [2:0] C_NONE = 3'd0;
  localparam logic [2:0] C_SIZE = 3'd1;
  localparam logic [2:0] C_ALGN = 3'd2;
  localparam logic [2:0] C_RNGE = 3'd3;
  localparam logic [2:0] C_WDTH = 3'd4;
  localparam logic [2:0] C_RDON = 3'd5;

  logic [ADDR_W-1:0] r_base  [NUM_REGIONS];
  logic [ADDR_W-1:0] r_limit [NUM_REGIONS];
  logic [2:0]        r_attr  [NUM_REGIONS];

  logic              r_res_valid;
  logic              r_res_error;
  logic [2:0]        r_res_cause;
  logic [ADDR_W-1:0] r_res_addr;
  logic              r_res_write;

  logic              r_cap_valid;
  logic [ADDR_W-1:0] r_cap_addr;
  logic [2:0]        r_cap_cause;
  logic              r_cap_write;

  logic              w_hit;
  logic              w_ro;
  logic              w_wo;
  logic [2:0]        w_cause;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGIONS; i++) begin
        r_base[i]  <= '0;
        r_limit[i] <= '0;
        r_attr[i]  <= '0;
      end
    end else if (cfg_we && (int'(cfg_idx) < NUM_REGIONS)) begin
      case (cfg_sel)
        2'd0:    r_base[cfg_idx]  <= cfg_wdata;
        2'd1:    r_limit[cfg_idx] <= cfg_wdata;
        2'd2:    r_attr[cfg_idx]  <= cfg_wdata[2:0];
        default: ;
      endcase
    end
  end

  // Scan from the top so the lowest matching index is the one left standing.
  always_comb begin
    w_hit = 1'b0;
    w_ro  = 1'b0;
    w_wo  = 1'b0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (r_attr[i][0] && (chk_addr >= r_base[i]) && (chk_addr <= r_limit[i])) begin
        w_hit = 1'b1;
        w_ro  = r_attr[i][1];
        w_wo  = r_attr[i][2];
      end
    end
  end

  always_comb begin
    w_cause = C_NONE;
    if (chk_size == 2'd3)
      w_cause = C_SIZE;
    else if ((chk_size == 2'd2 && chk_addr[1:0] != 2'b00) || (chk_size == 2'd1 && chk_addr[0]))
      w_cause = C_ALGN;
    else if (!w_hit)
      w_cause = C_RNGE;
    else if (w_wo && chk_size != 2'd2)
      w_cause = C_WDTH;
    else if (chk_write && w_ro)
      w_cause = C_RDON;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_res_valid <= 1'b0;
      r_res_error <= 1'b0;
      r_res_cause <= '0;
      r_res_addr  <= '0;
      r_res_write <= 1'b0;
    end else begin
      r_res_valid <= chk_valid;
      r_res_error <= chk_valid && (w_cause != C_NONE);
      r_res_cause <= chk_valid ? w_cause : C_NONE;
      r_res_addr  <= chk_addr;
      r_res_write <= chk_write;
    end
  end

  // A clear in the same cycle as a fault frees the register for that fault.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cap_valid <= 1'b0;
      r_cap_addr  <= '0;
      r_cap_cause <= '0;
      r_cap_write <= 1'b0;
    end else if (r_res_error && (!r_cap_valid || cap_clr)) begin
      r_cap_valid <= 1'b1;
      r_cap_addr  <= r_res_addr;
      r_cap_cause <= r_res_cause;
      r_cap_write <= r_res_write;
    end else if (cap_clr) begin
      r_cap_valid <= 1'b0;
    end
  end

`ifdef MAG_ERRCNT_EN
  logic [CNT_W-1:0] r_err_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_err_cnt <= '0;
    else if (cap_clr)
      r_err_cnt <= r_res_error ? CNT_W'(1) : '0;
    else if (r_res_error && (r_err_cnt != '1))
      r_err_cnt <= r_err_cnt + CNT_W'(1);
  end

  assign err_cnt = r_err_cnt;
`else
  assign err_cnt = '0;
`endif

  assign res_valid = r_res_valid;
  assign res_error = r_res_error;
  assign res_cause = r_res_cause;
  assign cap_valid = r_cap_valid;
  assign cap_addr  = r_cap_addr;
  assign cap_cause = r_cap_cause;
  assign cap_write = r_cap_write;

endmodule

// File: tb/tb_mem_access_guard.sv
// Directed bench for mem_access_guard: vector tables for cause decode, plus hand-written sequences
// for config timing, capture semantics, the fault counter and mid-operation reset.
module tb_mem_access_guard;

  logic        clk;
  logic        reset;
  logic        chk_valid;
  logic [31:0] chk_addr;
  logic [1:0]  chk_size;
  logic        chk_write;
  logic        res_valid;
  logic        res_error;
  logic [2:0]  res_cause;
  logic        cfg_we;
  logic [2:0]  cfg_idx;
  logic [1:0]  cfg_sel;
  logic [31:0] cfg_wdata;
  logic        cap_valid;
  logic [31:0] cap_addr;
  logic [2:0]  cap_cause;
  logic        cap_write;
  logic        cap_clr;
  logic [3:0]  err_cnt;

  int n_total = 0;
  int n_pass  = 0;

  mem_access_guard #(.ADDR_W(32), .NUM_REGIONS(8), .IDX_W(3), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .chk_valid(chk_valid), .chk_addr(chk_addr), .chk_size(chk_size), .chk_write(chk_write),
    .res_valid(res_valid), .res_error(res_error), .res_cause(res_cause),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_sel(cfg_sel), .cfg_wdata(cfg_wdata),
    .cap_valid(cap_valid), .cap_addr(cap_addr), .cap_cause(cap_cause), .cap_write(cap_write),
    .cap_clr(cap_clr), .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  size;
    logic        wr;
    logic [2:0]  cause;
  } vec_t;

  vec_t vecs [18];

`ifdef MAG_ERRCNT_EN
  localparam logic [3:0] EXP_SAT = 4'd15;
  localparam logic [3:0] EXP_ONE = 4'd1;
`else
  localparam logic [3:0] EXP_SAT = 4'd0;
  localparam logic [3:0] EXP_ONE = 4'd0;
`endif

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic cfg_write(input logic [2:0] idx, input logic [1:0] sel, input logic [31:0] data);
    @(negedge clk);
    cfg_we = 1'b1; cfg_idx = idx; cfg_sel = sel; cfg_wdata = data;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic cfg_region(input logic [2:0] idx, input logic [31:0] b, input logic [31:0] l,
                            input logic [2:0] a);
    cfg_write(idx, 2'd0, b);
    cfg_write(idx, 2'd1, l);
    cfg_write(idx, 2'd2, {29'd0, a});
  endtask

  task automatic do_chk(input string nm, input logic [31:0] a, input logic [1:0] s,
                        input logic w, input logic [2:0] exp_cause);
    @(negedge clk);
    chk_valid = 1'b1; chk_addr = a; chk_size = s; chk_write = w;
    @(negedge clk);
    chk_valid = 1'b0;
    check({nm, " valid"}, {31'd0, res_valid}, 32'd1);
    check({nm, " error"}, {31'd0, res_error}, {31'd0, exp_cause != 3'd0});
    check({nm, " cause"}, {29'd0, res_cause}, {29'd0, exp_cause});
  endtask

  task automatic clear_cap();
    @(negedge clk);
    cap_clr = 1'b1;
    @(negedge clk);
    cap_clr = 1'b0;
  endtask

  initial begin
    reset = 1'b0; chk_valid = 1'b0; chk_addr = '0; chk_size = '0; chk_write = 1'b0;
    cfg_we = 1'b0; cfg_idx = '0; cfg_sel = '0; cfg_wdata = '0; cap_clr = 1'b0;

    vecs[0]  = '{32'h1000, 2'd2, 1'b0, 3'd0};
    vecs[1]  = '{32'h1002, 2'd2, 1'b0, 3'd2};
    vecs[2]  = '{32'h1002, 2'd1, 1'b0, 3'd0};
    vecs[3]  = '{32'h1000, 2'd3, 1'b0, 3'd1};
    vecs[4]  = '{32'h1001, 2'd1, 1'b0, 3'd2};
    vecs[5]  = '{32'h2FFF, 2'd0, 1'b1, 3'd0};
    vecs[6]  = '{32'h3000, 2'd0, 1'b0, 3'd3};
    vecs[7]  = '{32'h0000, 2'd2, 1'b1, 3'd0};
    vecs[8]  = '{32'h3001, 2'd3, 1'b0, 3'd1};
    vecs[9]  = '{32'h7F08, 2'd2, 1'b1, 3'd5};
    vecs[10] = '{32'h7F04, 2'd2, 1'b1, 3'd0};
    vecs[11] = '{32'h7F04, 2'd0, 1'b1, 3'd4};
    vecs[12] = '{32'h7F08, 2'd2, 1'b0, 3'd0};
    vecs[13] = '{32'h7F08, 2'd0, 1'b1, 3'd5};
    vecs[14] = '{32'h7F09, 2'd0, 1'b0, 3'd0};
    vecs[15] = '{32'h7F0C, 2'd2, 1'b0, 3'd3};
    vecs[16] = '{32'h7F02, 2'd1, 1'b0, 3'd4};
    vecs[17] = '{32'h8800, 2'd2, 1'b0, 3'd3};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst res_valid", {31'd0, res_valid}, 32'd0);
    check("rst res_error", {31'd0, res_error}, 32'd0);
    check("rst cap_valid", {31'd0, cap_valid}, 32'd0);
    check("rst cap_addr", cap_addr, 32'd0);
    check("rst err_cnt", {28'd0, err_cnt}, 32'd0);
    reset = 1'b1;

    // Empty table: everything is out of range; first fault captured
    do_chk("t1 lw 0", 32'h0, 2'd2, 1'b0, 3'd3);
    @(negedge clk);
    check("t1 cap_valid", {31'd0, cap_valid}, 32'd1);
    check("t1 cap_addr", cap_addr, 32'h0);
    check("t1 cap_cause", {29'd0, cap_cause}, 32'd3);
    check("t1 cap_write", {31'd0, cap_write}, 32'd0);

    cfg_region(3'd0, 32'h0000, 32'h2FFF, 3'b001);
    for (int i = 0; i < 9; i++)
      do_chk($sformatf("vec%0d", i), vecs[i].addr, vecs[i].size, vecs[i].wr, vecs[i].cause);

    cfg_region(3'd0, 32'h7F08, 32'h7F0B, 3'b011);
    cfg_region(3'd1, 32'h7F00, 32'h7F0B, 3'b101);
    cfg_region(3'd3, 32'h9000, 32'h8000, 3'b001);
    for (int i = 9; i < 18; i++)
      do_chk($sformatf("vec%0d", i), vecs[i].addr, vecs[i].size, vecs[i].wr, vecs[i].cause);

    check("t1 cap held", cap_addr, 32'h0);

    // Config write in the same cycle as an access still sees the old table
    cfg_write(3'd2, 2'd0, 32'h4000);
    cfg_write(3'd2, 2'd1, 32'h4FFF);
    @(negedge clk);
    cfg_we = 1'b1; cfg_idx = 3'd2; cfg_sel = 2'd2; cfg_wdata = 32'h1;
    chk_valid = 1'b1; chk_addr = 32'h4000; chk_size = 2'd2; chk_write = 1'b0;
    @(negedge clk);
    cfg_we = 1'b0;
    check("t4 same-cycle cause", {29'd0, res_cause}, 32'd3);
    @(negedge clk);
    chk_valid = 1'b0;
    check("t4 next-cycle cause", {29'd0, res_cause}, 32'd0);
    check("t4 next-cycle error", {31'd0, res_error}, 32'd0);

    // cfg_sel=3 is ignored
    cfg_write(3'd2, 2'd3, 32'h0);
    do_chk("t4 sel3 ignored", 32'h4004, 2'd2, 1'b1, 3'd0);

    // First-fault capture, then clear racing a new fault
    clear_cap();
    check("t5 cleared", {31'd0, cap_valid}, 32'd0);
    @(negedge clk);
    chk_valid = 1'b1; chk_addr = 32'hA000; chk_size = 2'd2; chk_write = 1'b1;
    @(negedge clk);
    chk_addr = 32'hB000; chk_write = 1'b0;
    @(negedge clk);
    chk_valid = 1'b0;
    check("t5 B error", {31'd0, res_error}, 32'd1);
    @(negedge clk);
    check("t5 cap_addr A", cap_addr, 32'hA000);
    check("t5 cap_write A", {31'd0, cap_write}, 32'd1);
    @(negedge clk);
    chk_valid = 1'b1; chk_addr = 32'hC000; chk_size = 2'd3; chk_write = 1'b0;
    @(negedge clk);
    chk_valid = 1'b0; cap_clr = 1'b1;
    @(negedge clk);
    cap_clr = 1'b0;
    check("t5 cap_valid C", {31'd0, cap_valid}, 32'd1);
    check("t5 cap_addr C", cap_addr, 32'hC000);
    check("t5 cap_cause C", {29'd0, cap_cause}, 32'd1);
    check("t5 err_cnt clr+fault", {28'd0, err_cnt}, {28'd0, EXP_ONE});

    // Saturating counter
    clear_cap();
    check("t6 cnt cleared", {28'd0, err_cnt}, 32'd0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk_valid = 1'b1; chk_addr = 32'hD000 + 32'(i); chk_size = 2'd3; chk_write = 1'b0;
    end
    @(negedge clk);
    chk_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("t6 cnt saturated", {28'd0, err_cnt}, {28'd0, EXP_SAT});
    check("t6 cap first", cap_addr, 32'hD000);
    clear_cap();
    check("t6 cnt after clr", {28'd0, err_cnt}, 32'd0);
    check("t6 cap after clr", {31'd0, cap_valid}, 32'd0);

    // Reset mid-operation drops the in-flight result and disables the table
    @(negedge clk);
    chk_valid = 1'b1; chk_addr = 32'h4000; chk_size = 2'd2; chk_write = 1'b0;
    #2 reset = 1'b0;
    @(negedge clk);
    chk_valid = 1'b0;
    check("rst2 res_valid", {31'd0, res_valid}, 32'd0);
    check("rst2 res_error", {31'd0, res_error}, 32'd0);
    reset = 1'b1;
    do_chk("rst2 table gone", 32'h4000, 2'd2, 1'b0, 3'd3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
